cache_refill_ctrl: RTL and testbench

Miss-refill sequencer for the L1 data cache line array. On a cache miss it issues one line-aligned 16-beat burst read to memory and assembles the returned words into a 512-bit line buffer. For a store miss it merges the pending store under its byte mask, then writes the whole line into the line SRAM in a single cycle. It sits between the cache hit/miss logic and the memory bus, and is the only writer of the line SRAM during a refill.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/refill_line_buffer.sv | 64 ++++++
 rtl/cache_refill_ctrl.sv | 146 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 data cache refill path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

    // Refill sequencer states, in the order a refill walks through them.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        WRITE,
        DONE
    } state_t;

    localparam int        WORDS_PER_LINE = 16;
    localparam int        WORD_IDX_BITS  = 4;      // log2(WORDS_PER_LINE)
    localparam int        OFFSET_BITS    = 6;      // byte offset within a 64-byte line
    localparam logic [7:0] BURST_LEN     = 8'd15;  // AXI-style len: beats - 1

endpackage

// File: rtl/refill_line_buffer.sv
// Line assembly buffer: one word written per accepted beat, store data merged on the output.
// Latency: a written word is visible on line/word the cycle after wr_en; merge is combinational.
// Backpressure: none; the owner decides when wr_en is asserted.
//
// Ports:
//   clk, reset          clock, async active-high reset (clears every word)
//   wr_en/wr_idx/wr_data  word write port, indexed by beat number
//   merge_en/idx/data/mask  pending store overlaid bytewise on word merge_idx
//   line                whole merged line
//   word                merged word at merge_idx
module refill_line_buffer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [WORD_IDX_BITS-1:0]             wr_idx,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 merge_en,
    input  logic [WORD_IDX_BITS-1:0]             merge_idx,
    input  logic [DATA_WIDTH-1:0]                merge_data,
    input  logic [DATA_WIDTH/8-1:0]              merge_mask,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line,
    output logic [DATA_WIDTH-1:0]                word
);

    logic [DATA_WIDTH-1:0] words [WORDS_PER_LINE];
    logic [DATA_WIDTH-1:0] ext_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    // Byte-enable to bit-mask expansion.
    always_comb begin
        ext_mask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            ext_mask[b*8 +: 8] = {8{merge_mask[b]}};
        end
    end

    // Only the store's word is touched; a zero mask leaves the fetched line intact.
    always_comb begin
        line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            line[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
        end
        if (merge_en) begin
            line[int'(merge_idx)*DATA_WIDTH +: DATA_WIDTH] =
                (words[merge_idx] & ~ext_mask) | (merge_data & ext_mask);
        end
    end

    assign word = line[int'(merge_idx)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss refill sequencer: one 16-beat burst read, line assembly, store merge, single-cycle SRAM write.
// Latency: 20 cycles miss-accept to ready again with no stalls; each bus stall cycle adds one.
// Backpressure: miss_ready low while busy (requester holds miss_valid); ar held until ar_ready; beats taken only on r_valid.
//
// Ports:
//   clk, reset                              clock, async active-high reset
//   miss_valid/ready/addr/wr/wdata/wmask    miss request from hit/miss logic
//   mem_ar_valid/ready/addr/len             burst read request (line aligned, 16 beats)
//   mem_r_valid/ready/data/last             read beats
//   sram_we/waddr/wdata                     full-line write into the line SRAM
//   done_valid/done_rdata                   completion pulse and word at the miss offset
//   fill_err                                pulse when mem_r_last disagrees with the beat count
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int Cache_line_size = 512,
    parameter int Index_len       = 6,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_WIDTH-1:0]      miss_addr,
    input  logic                       miss_wr,
    input  logic [DATA_WIDTH-1:0]      miss_wdata,
    input  logic [DATA_WIDTH/8-1:0]    miss_wmask,
    output logic                       mem_ar_valid,
    input  logic                       mem_ar_ready,
    output logic [ADDR_WIDTH-1:0]      mem_ar_addr,
    output logic [7:0]                 mem_ar_len,
    input  logic                       mem_r_valid,
    output logic                       mem_r_ready,
    input  logic [DATA_WIDTH-1:0]      mem_r_data,
    input  logic                       mem_r_last,
    output logic                       sram_we,
    output logic [Index_len-1:0]       sram_waddr,
    output logic [Cache_line_size-1:0] sram_wdata,
    output logic                       done_valid,
    output logic [DATA_WIDTH-1:0]      done_rdata,
    output logic                       fill_err
);

    localparam int WORD_LSB = $clog2(DATA_WIDTH/8);

    state_t                    state, state_nxt;
    logic [WORD_IDX_BITS-1:0]  cnt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      wr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wmask_q;

    logic                      beat;
    logic                      last_beat;
    logic [Cache_line_size-1:0] line;
    logic [DATA_WIDTH-1:0]     word;
    logic                      unused_addr_lsb;

    assign beat      = (state == FILL) && mem_r_valid;
    assign last_beat = (cnt == WORD_IDX_BITS'(WORDS_PER_LINE - 1));

    // Byte-within-word bits never select anything.
    assign unused_addr_lsb = ^addr_q[WORD_LSB-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss_valid) begin
                addr_q  <= miss_addr;
                wr_q    <= miss_wr;
                wdata_q <= miss_wdata;
                wmask_q <= miss_wmask;
                cnt     <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        miss_ready   = 1'b0;
        mem_ar_valid = 1'b0;
        mem_r_ready  = 1'b0;
        sram_we      = 1'b0;
        done_valid   = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_nxt = REQ;
            end
            REQ: begin
                mem_ar_valid = 1'b1;
                if (mem_ar_ready) state_nxt = FILL;
            end
            FILL: begin
                mem_r_ready = 1'b1;
                // The count alone ends the burst; mem_r_last is only cross-checked.
                if (mem_r_valid && last_beat) state_nxt = WRITE;
            end
            WRITE: begin
                sram_we   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_ar_len  = BURST_LEN;
    assign mem_ar_addr = (state == REQ) ? {addr_q[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)} : '0;
    assign fill_err    = beat && (mem_r_last != last_beat);

    // Everything feeding the SRAM comes from flops, never straight from mem_r_*.
    assign sram_waddr  = (state == WRITE) ? addr_q[OFFSET_BITS +: Index_len] : '0;
    assign sram_wdata  = (state == WRITE) ? line : '0;
    assign done_rdata  = (state == DONE) ? word : '0;

    refill_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (beat),
        .wr_idx     (cnt),
        .wr_data    (mem_r_data),
        .merge_en   (wr_q),
        .merge_idx  (addr_q[WORD_LSB +: WORD_IDX_BITS]),
        .merge_data (wdata_q),
        .merge_mask (wmask_q),
        .line       (line),
        .word       (word)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus randomized misses against a line/timing model.
// Latency: n/a.
// Backpressure: bench drives ar_ready/r_valid stall patterns.
module tb_cache_refill_ctrl;

    localparam int MAXC = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic         miss_wr;
    logic [31:0]  miss_wdata;
    logic [3:0]   miss_wmask;
    logic         mem_ar_valid;
    logic         mem_ar_ready;
    logic [31:0]  mem_ar_addr;
    logic [7:0]   mem_ar_len;
    logic         mem_r_valid;
    logic         mem_r_ready;
    logic [31:0]  mem_r_data;
    logic         mem_r_last;
    logic         sram_we;
    logic [5:0]   sram_waddr;
    logic [511:0] sram_wdata;
    logic         done_valid;
    logic [31:0]  done_rdata;
    logic         fill_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] beat_dat [16];
    logic [31:0] nxt_addr, nxt_wdata;
    logic        nxt_wr;
    logic [3:0]  nxt_wmask;
    logic [31:0] got_rd;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .miss_wr      (miss_wr),
        .miss_wdata   (miss_wdata),
        .miss_wmask   (miss_wmask),
        .mem_ar_valid (mem_ar_valid),
        .mem_ar_ready (mem_ar_ready),
        .mem_ar_addr  (mem_ar_addr),
        .mem_ar_len   (mem_ar_len),
        .mem_r_valid  (mem_r_valid),
        .mem_r_ready  (mem_r_ready),
        .mem_r_data   (mem_r_data),
        .mem_r_last   (mem_r_last),
        .sram_we      (sram_we),
        .sram_waddr   (sram_waddr),
        .sram_wdata   (sram_wdata),
        .done_valid   (done_valid),
        .done_rdata   (done_rdata),
        .fill_err     (fill_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk1 ({tag, "_miss_ready"}, miss_ready,   1'b1);
        chk1 ({tag, "_ar_valid"},   mem_ar_valid, 1'b0);
        chk32({tag, "_ar_addr"},    mem_ar_addr,  32'h0);
        chk32({tag, "_ar_len"},     32'(mem_ar_len), 32'd15);
        chk1 ({tag, "_r_ready"},    mem_r_ready,  1'b0);
        chk1 ({tag, "_sram_we"},    sram_we,      1'b0);
        chk32({tag, "_sram_waddr"}, 32'(sram_waddr), 32'h0);
        chk512({tag, "_sram_wdata"}, sram_wdata,  512'h0);
        chk1 ({tag, "_done_valid"}, done_valid,   1'b0);
        chk32({tag, "_done_rdata"}, done_rdata,   32'h0);
        chk1 ({tag, "_fill_err"},   fill_err,     1'b0);
    endtask

    task automatic rand_beats();
        for (int k = 0; k < 16; k++) beat_dat[k] = $urandom;
    endtask

    // One complete miss. rv_mode: 0 = r_valid every cycle, 1 = valid on odd cycles, 2 = random.
    // last_at: beat index carrying mem_r_last. abort_at: accepted-beat count at which reset hits (-1 = never).
    // hold: keep miss_valid high with the nxt_* request throughout the refill.
    task automatic run_miss(input logic [31:0] a, input logic w, input logic [31:0] wd,
                            input logic [3:0] wm, input int ar_stall, input int rv_mode,
                            input int last_at, input int abort_at, input bit hold,
                            output logic [31:0] rd);
        bit           rv [MAXC];
        logic [511:0] exp_line;
        logic [31:0]  exp_word;
        int           fill_start, last_beat_cyc, n, beats, off;
        bit           exp_rr, exp_err;

        // Model: timing from the stall pattern, line content from beats and the store.
        for (int c = 0; c < MAXC; c++) begin
            case (rv_mode)
                0:       rv[c] = 1'b1;
                1:       rv[c] = (c % 2) == 1;
                default: rv[c] = ($urandom_range(0, 3) != 0) || (c >= 120);
            endcase
        end
        fill_start    = ar_stall + 2;
        n             = 0;
        last_beat_cyc = MAXC - 3;
        for (int c = fill_start; c < MAXC - 2; c++) begin
            if (rv[c] && n < 16) begin
                n++;
                if (n == 16) last_beat_cyc = c;
            end
        end
        off = int'(a[5:2]);
        for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = beat_dat[k];
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (wm[b]) exp_line[off*32 + b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        exp_word = exp_line[off*32 +: 32];
        rd = 32'hx;

        // Cycle 0: miss presented while idle.
        miss_valid   = 1'b1;
        miss_addr    = a;
        miss_wr      = w;
        miss_wdata   = wd;
        miss_wmask   = wm;
        mem_ar_ready = 1'b0;
        mem_r_valid  = 1'b0;
        mem_r_last   = 1'b0;
        @(negedge clk);
        chk1("idle_ready", miss_ready, 1'b1);
        @(posedge clk); #1;
        if (hold) begin
            miss_addr  = nxt_addr;
            miss_wr    = nxt_wr;
            miss_wdata = nxt_wdata;
            miss_wmask = nxt_wmask;
        end else begin
            miss_valid = 1'b0;
        end

        beats = 0;
        for (int c = 1; c <= last_beat_cyc + 2; c++) begin
            exp_rr       = (c >= fill_start) && (c <= last_beat_cyc);
            mem_ar_ready = (c > ar_stall);
            mem_r_valid  = rv[c];
            mem_r_data   = (rv[c] && exp_rr) ? beat_dat[beats] : $urandom;
            mem_r_last   = rv[c] && (beats == last_at);
            exp_err      = rv[c] && exp_rr && ((beats == last_at) != (beats == 15));
            @(negedge clk);
            chk1("busy_ready", miss_ready, 1'b0);
            chk1("ar_valid", mem_ar_valid, c <= ar_stall + 1);
            if (c <= ar_stall + 1) begin
                chk32("ar_addr", mem_ar_addr, a & 32'hFFFF_FFC0);
                chk32("ar_len", 32'(mem_ar_len), 32'd15);
            end
            chk1("r_ready", mem_r_ready, exp_rr);
            chk1("fill_err", fill_err, exp_err);
            chk1("sram_we", sram_we, c == last_beat_cyc + 1);
            if (c == last_beat_cyc + 1) begin
                chk32("sram_waddr", 32'(sram_waddr), 32'(a[11:6]));
                chk512("sram_wdata", sram_wdata, exp_line);
            end
            chk1("done_valid", done_valid, c == last_beat_cyc + 2);
            if (c == last_beat_cyc + 2) begin
                chk32("done_rdata", done_rdata, exp_word);
                rd = done_rdata;
            end
            if (rv[c] && exp_rr) beats++;
            if (abort_at >= 0 && beats == abort_at) begin
                #2 reset = 1'b1;
                #1 chk_reset_outs("mid_fill_reset");
                miss_valid  = 1'b0;
                mem_r_valid = 1'b0;
                mem_r_last  = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                for (int i = 0; i < 25; i++) begin
                    @(negedge clk);
                    chk1("post_reset_we", sram_we, 1'b0);
                    chk1("post_reset_done", done_valid, 1'b0);
                    chk1("post_reset_ready", miss_ready, 1'b1);
                    @(posedge clk); #1;
                end
                return;
            end
            @(posedge clk); #1;
        end
        if (!hold) miss_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        miss_valid   = 1'b0;
        miss_addr    = '0;
        miss_wr      = 1'b0;
        miss_wdata   = '0;
        miss_wmask   = '0;
        mem_ar_ready = 1'b0;
        mem_r_valid  = 1'b0;
        mem_r_data   = '0;
        mem_r_last   = 1'b0;
        nxt_addr     = '0;
        nxt_wr       = 1'b0;
        nxt_wdata    = '0;
        nxt_wmask    = '0;

        #3 chk_reset_outs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Load miss at 0x1240, beats 0x1000+k, no stalls.
        for (int k = 0; k < 16; k++) beat_dat[k] = 32'h1000 + k;
        run_miss(32'h0000_1240, 1'b0, 32'h0, 4'h0, 0, 0, 15, -1, 1'b0, got_rd);
        chk32("load_rdata_literal", got_rd, 32'h0000_1000);

        // Store miss at 0x8 merging bytes 0 and 2.
        rand_beats();
        beat_dat[2] = 32'h1122_3344;
        run_miss(32'h0000_0008, 1'b1, 32'hAABB_CCDD, 4'b0101, 0, 0, 15, -1, 1'b0, got_rd);
        chk32("store_rdata_literal", got_rd, 32'h11BB_33DD);

        // Store miss with empty mask leaves the line as fetched.
        rand_beats();
        run_miss(32'h0000_2F34, 1'b1, 32'hDEAD_BEEF, 4'b0000, 0, 0, 15, -1, 1'b0, got_rd);

        // ar_ready low 5 cycles, r_valid alternating.
        rand_beats();
        run_miss($urandom, 1'b0, 32'h0, 4'h0, 5, 1, 15, -1, 1'b0, got_rd);

        // mem_r_last early on beat 7 (and thus missing on beat 15).
        rand_beats();
        run_miss($urandom, 1'b1, $urandom, 4'b1001, 1, 0, 7, -1, 1'b0, got_rd);

        // Reset after beat 9, then a clean refill.
        rand_beats();
        run_miss(32'h0000_4480, 1'b0, 32'h0, 4'h0, 0, 0, 15, 10, 1'b0, got_rd);
        rand_beats();
        run_miss(32'h0000_44BC, 1'b1, 32'h0102_0304, 4'b1111, 0, 2, 15, -1, 1'b0, got_rd);

        // Second miss held high during a refill; it is taken at the first ready cycle.
        nxt_addr  = 32'h0000_7E04;
        nxt_wr    = 1'b1;
        nxt_wdata = 32'hCAFE_F00D;
        nxt_wmask = 4'b0110;
        rand_beats();
        run_miss(32'h0000_3000, 1'b0, 32'h0, 4'h0, 2, 2, 15, -1, 1'b1, got_rd);
        rand_beats();
        run_miss(nxt_addr, nxt_wr, nxt_wdata, nxt_wmask, 0, 0, 15, -1, 1'b0, got_rd);

        // Randomized misses.
        for (int t = 0; t < 8; t++) begin
            rand_beats();
            run_miss($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), 2, 15, -1, 1'b0, got_rd);
        end

        @(negedge clk);
        chk1("final_ready", miss_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
